chunked_adder: RTL and testbench

CHUNKED_ADDER -- requirements
Module: chunked_adder

---
 rtl/chunked_adder_pkg.sv | 13 +
 rtl/chunked_adder_chunk_add.sv | 30 +++
 rtl/chunked_adder.sv | 119 +++++++++++
 tb/tb_chunked_adder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/chunked_adder_pkg.sv
// Shared types and default geometry for the chunk-serial adder.
package chunked_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunked_adder_chunk_add.sv
// chunk_add: combinational CHUNK-bit ripple adder; also exposes the carry into its top bit.
module chunk_add
  import chunked_adder_pkg::*;
#(
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Chunk-serial adder: WIDTH-bit add performed CHUNK bits per clock with valid/ready handshakes.
// Define ADDER_SUB_EN to add the sub port (a - b via ~b and carry-in 1).
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCH = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("chunked_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] op_b;
  logic             carry0;
  logic [CHUNK-1:0] ch_s;
  logic             ch_co, ch_msb;
  logic             last;
  logic [31:0]      base;

  // Operand B and initial carry as latched on accept
`ifdef ADDER_SUB_EN
  assign op_b   = sub ? ~b : b;
  assign carry0 = sub ? 1'b1 : cin;
`else
  assign op_b   = b;
  assign carry0 = cin;
`endif

  assign last = (idx == IW'(NCH - 1));
  assign base = 32'(idx) * CHUNK;

  // Operands are shifted right each RUN cycle so the live chunk is always at bit 0
  chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .ci    (carry),
    .s     (ch_s),
    .co    (ch_co),
    .c_msb (ch_msb)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= op_b;
            carry <= carry0;
            idx   <= '0;
          end
        end
        RUN: begin
          a_q               <= a_q >> CHUNK;
          b_q               <= b_q >> CHUNK;
          sum[base +: CHUNK] <= ch_s;
          carry             <= ch_co;
          idx               <= idx + IW'(1);
          if (last) begin
            cout <= ch_co;
            ovf  <= ch_co ^ ch_msb;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder: reference model plus directed vectors with literal results.
module tb_chunked_adder;

  localparam int unsigned W = 16;
  localparam int unsigned C = 4;
  localparam int unsigned N = W / C;
`ifdef ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;

  logic         in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
  logic [7:0]   a8 = '0, b8 = '0;
  logic         in_ready8, out_valid8, cout8, ovf8;
  logic [7:0]   sum8;

  chunked_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8),
`ifdef ADDER_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic and the latency/handshake rules
  bit           started = 1'b0;
  bit           m_busy  = 1'b0;
  bit           m_zero  = 1'b1;
  int           m_cnt   = 0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0, m_ovf = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] ob;
    logic [W:0]   full;
    logic         c0;
    if (rst) begin
      m_busy  = 1'b0;
      m_cnt   = 0;
      m_zero  = 1'b1;
      started = 1'b1;
    end else if (!m_busy) begin
      if (in_valid) begin
        ob     = (SUB_EN && sub) ? ~b : b;
        c0     = (SUB_EN && sub) ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, ob} + (W+1)'(c0);
        m_sum  = full[W-1:0];
        m_cout = full[W];
        m_ovf  = (a[W-1] == ob[W-1]) && (m_sum[W-1] != a[W-1]);
        m_busy = 1'b1;
        m_cnt  = 0;
        m_zero = 1'b0;
      end
    end else if (m_cnt < int'(N)) begin
      m_cnt++;
    end else if (out_ready) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", 32'(in_ready), 32'(!m_busy));
      check("out_valid", 32'(out_valid), 32'(m_busy && m_cnt == int'(N)));
      if (m_busy && m_cnt == int'(N)) begin
        check("sum", 32'(sum), 32'(m_sum));
        check("cout", 32'(cout), 32'(m_cout));
        check("ovf", 32'(ovf), 32'(m_ovf));
      end
      if (!m_busy && m_zero) begin
        check("sum_reset", 32'(sum), 32'h0);
        check("flags_reset", {30'd0, cout, ovf}, 32'h0);
      end
    end
  end

  // One transaction on the 16-bit instance; hold = cycles to stall in DONE with fresh in_valid traffic
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic ts, input int hold,
                       output logic [W-1:0] rs, output logic rc, output logic ro);
    int lat;
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(N));
    for (int i = 0; i < hold; i++) begin
      a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
      @(negedge clk);
    end
    rs = sum; rc = cout; ro = ovf;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [W-1:0] rs;
  logic         rc, ro;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_sum", 32'(sum), 32'h0);

    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, rs, rc, ro);
    check("v1_sum", 32'(rs), 32'h2233);
    check("v1_flags", {30'd0, rc, ro}, 32'h0);

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, rs, rc, ro);
    check("wrap_sum", 32'(rs), 32'h0000);
    check("wrap_flags", {30'd0, rc, ro}, 32'h2);

    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, rs, rc, ro);
    check("povf_sum", 32'(rs), 32'h8000);
    check("povf_flags", {30'd0, rc, ro}, 32'h1);

    do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 0, rs, rc, ro);
    check("novf_sum", 32'(rs), 32'h0001);
    check("novf_flags", {30'd0, rc, ro}, 32'h3);

    // Stall in DONE with new operands offered: must not be accepted
    do_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 10, rs, rc, ro);
    check("stall_sum", 32'(rs), 32'hBCDF);
    check("stall_flags", {30'd0, rc, ro}, 32'h0);
    check("stall_idle", 32'(in_ready), 32'h1);

`ifdef ADDER_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, rs, rc, ro);
    check("sub_sum", 32'(rs), 32'hFFFE);
    check("sub_cout", 32'(rc), 32'h0);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0, rs, rc, ro);
    check("subovf_sum", 32'(rs), 32'h7FFF);
    check("subovf_flags", {30'd0, rc, ro}, 32'h3);
    sub = 1'b0;
`endif

    // Reset on the second RUN edge abandons the operation
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'h1);
    check("abort_sum", 32'(sum), 32'h0);
    check("abort_out_valid", 32'(out_valid), 32'h0);
    repeat (8) @(negedge clk);

    // Single-chunk instance: one-cycle latency
    a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b1; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    check("w8_busy", 32'(in_ready8), 32'h0);
    @(negedge clk);
    check("w8_valid", 32'(out_valid8), 32'h1);
    check("w8_sum", 32'(sum8), 32'h2D);
    check("w8_flags", {30'd0, cout8, ovf8}, 32'h2);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check("w8_idle", {30'd0, in_ready8, out_valid8}, 32'h2);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
